// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel frame receiver: start bit, WIDTH data bits, optional even parity, stop bit.
// Optional parity bit and parity_err port are enabled by defining SIPO_RX_PARITY_EN.
module sipo_frame_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
`ifdef SIPO_RX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef SIPO_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t          state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
`ifdef SIPO_RX_PARITY_EN
  logic             par;
  logic             par_bad;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
      par        <= 1'b0;
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // A load in STOP below overrides this clear, keeping dout_valid high.
      if (dout_valid && dout_ready)
        dout_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!din) begin
            state <= DATA;
            cnt   <= '0;
            busy  <= 1'b1;
`ifdef SIPO_RX_PARITY_EN
            par   <= 1'b0;
`endif
          end
        end
        DATA: begin
          if (MSB_FIRST)
            sr <= {sr[WIDTH-2:0], din};
          else
            sr <= {din, sr[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
`ifdef SIPO_RX_PARITY_EN
          par <= par ^ din;
          if (cnt == CW'(WIDTH - 1))
            state <= PARITY;
`else
          if (cnt == CW'(WIDTH - 1))
            state <= STOP;
`endif
        end
`ifdef SIPO_RX_PARITY_EN
        PARITY: begin
          par_bad <= par ^ din;
          state   <= STOP;
        end
`endif
        STOP: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!din)
            frame_err <= 1'b1;
`ifdef SIPO_RX_PARITY_EN
          else if (par_bad)
            parity_err <= 1'b1;
`endif
          else if (dout_valid && !dout_ready)
            overrun <= 1'b1;
          else begin
            dout       <= sr;
            dout_valid <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
